// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Round-robin arbiter in front of a W-bit register bank shared by N
//   requesters. Each granted requester applies one operation to the bank
//   (load / clear / preset / toggle), then must drop req before it can be
//   served again.
//
// Ports
//   clk   system clock, all state on rising edge
//   clr   synchronous active-high reset
//   req   [N-1:0]    level request per requester
//   op    [2N-1:0]   2-bit op per requester (00 load, 01 clear, 10 preset, 11 toggle)
//   din   [W*N-1:0]  load data per requester
//   gnt   [N-1:0]    registered one-hot grant
//   busy             high whenever the FSM is not in IDLE
//   Q     [W-1:0]    registered bank contents
//   _Q    [W-1:0]    ~Q
//
// Build option
//   REG_BANK_ARB_TOGGLE_EN : when defined, op 11 toggles Q; otherwise op 11
//   is a no-op that still completes the handshake and advances the pointer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant outstanding, searching req from ptr+1
// GRANT   | gnt high for one cycle, op applied at the closing edge
// RELEASE | waiting for the served requester to drop req

module reg_bank_arbiter #(
    parameter int W = 4,
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] op,
    input  logic [W*N-1:0] din,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   _Q
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   g, g_nx;
    logic [PW-1:0]   win;
    logic            found;
    logic [N-1:0]    gnt_nx;
    logic [W-1:0]    q_nx;
    logic [1:0]      g_op;
    logic [W-1:0]    g_din;

    // Round-robin search: the most recently served requester has lowest
    // priority, so the scan starts one past ptr and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign g_op  = op[2*g +: 2];
    assign g_din = din[W*g +: W];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        g_nx     = g;
        gnt_nx   = '0;
        q_nx     = Q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    gnt_nx   = N'(1) << win;
                    ptr_nx   = win;
                    g_nx     = win;
                end
            end
            GRANT: begin
                // committed regardless of req[g] during this cycle
                case (g_op)
                    2'b00:   q_nx = g_din;
                    2'b01:   q_nx = '0;
                    2'b10:   q_nx = '1;
                    default: begin
`ifdef REG_BANK_ARB_TOGGLE_EN
                        q_nx = ~Q;
`else
                        q_nx = Q;
`endif
                    end
                endcase
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (!req[g]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            ptr   <= PW'(N - 1);
            g     <= '0;
            gnt   <= '0;
            Q     <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            g     <= g_nx;
            gnt   <= gnt_nx;
            Q     <= q_nx;
        end
    end

    assign busy = (state != IDLE);
    assign _Q   = ~Q;

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Arbitrated controller for a W-bit D-trigger register bank shared by N requesters. Each requester asks for one bank operation (load, clear, preset, toggle) over a req/gnt handshake. The block grants one requester at a time in round-robin order and applies the granted operation to the bank, which it holds internally. It sits between the button/counter logic and the displayed register value in the trigger-and-counter designs.

## Interface
- `W`, default 4: bank width in bits.
- `N`, default 3: number of requesters (N ≥ 2).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `req`  in  N  request lines, one per requester; level-sensitive.
- `op`  in  2N  operation per requester; bits [2i+1:2i] belong to requester i. 00 = load, 01 = clear, 10 = preset, 11 = toggle.
- `din`  in  W·N  load data per requester; bits [W(i+1)-1:Wi] belong to requester i.
- `gnt`  out  N  one-hot grant, registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `Q`  out  W  bank contents, registered.
- `_Q`  out  W  always equal to ~Q.

## Operation
- FSM states are IDLE, GRANT and RELEASE.
- **IDLE**
  - If any `req` bit is high, pick winner g by round-robin: search starts at `ptr+1` mod N and wraps.
  - Latch g, set `gnt` = one-hot(g), set `ptr` = g, and go to GRANT.
  - If no `req` bit is high, stay in IDLE with `gnt` = 0.
- **GRANT** (exactly one cycle)
  - Apply requester g's operation to Q at the closing edge, using `op`/`din` sampled in this cycle:
    - load: Q ← din slice g.
    - clear: Q ← 0.
    - preset: Q ← all ones.
    - toggle: Q ← ~Q.
  - Clear `gnt` and go to RELEASE.
  - The operation is committed even if req[g] falls during GRANT.
- **RELEASE**
  - Wait until req[g] = 0, then go to IDLE.
  - Other requests stay pending and are not granted yet.
  - A requester must drop `req` before it can be granted again. Holding `req` high therefore yields exactly one operation.
- Requesters hold `op`/`din` stable from raising `req` until they see `gnt`.
- `busy` = (state ≠ IDLE).
- `_Q` is combinational from Q and never disagrees with it.
- Round-robin fairness: with all N requesters continuously cycling, every requester is served once per N grants.

## Timing
- **Reset:** `clr` high at an edge forces state = IDLE, Q = 0, `_Q` = all ones, `gnt` = 0, `busy` = 0 and `ptr` = N−1, so requester 0 wins first.
- `clr` dominates every other input in the same cycle.
- Reset during GRANT discards the pending operation; Q stays 0.
- **Latency:**
  - `req` high in IDLE at edge k gives `gnt` high in cycle k+1.
  - Q updates at edge k+2.
  - `busy` is high from k+1 until the edge after req[g] falls.
- **Back-to-back service:** minimum 3 cycles per grant. This assumes the requester drops `req` in the GRANT cycle, giving IDLE → GRANT → RELEASE → IDLE.
- **Simultaneous requests:** resolved purely by `ptr`. No requester has fixed priority.
- **Invalid input:** if req[g] is already low on entry to RELEASE, RELEASE lasts one cycle.

## Configuration
- Macro: `REG_BANK_ARB_TOGGLE_EN`.
- **Defined:** op 11 toggles Q as described above.
- **Undefined:** op 11 is a no-op. The handshake and grant proceed normally, Q is unchanged, and the round-robin pointer still advances.
- Ops 00/01/10 are identical in both builds.

## Test plan
- **Reset:** assert `clr` for 2 cycles with all `req` high → Q = 0x0, `_Q` = 0xF, `gnt` = 0, `busy` = 0. Release `clr` → first `gnt` = 3'b001.
- **Single load:** req[1] = 1, op = 00, din1 = 0xA, dropped after `gnt` → `gnt` = 3'b010 one cycle after `req`, Q = 0xA the cycle after, `busy` low 3 cycles after `req`.
- **Round-robin:** all three `req` held with loads 0x1/0x2/0x3, each dropping `req` on its grant and re-raising it → grant order 0, 1, 2, 0 and Q sequence 0x1, 0x2, 0x3, 0x1.
- **Held request:** req[2] held high for 10 cycles with preset → exactly one grant, Q = 0xF, FSM parked in RELEASE until req[2] falls.
- **Toggle:** from Q = 0x5, req[0] op = 11 → Q = 0xA with the macro defined, Q = 0x5 without it.
- **Reset mid-GRANT:** assert `clr` in the cycle `gnt` is high for a load of 0x7 → Q = 0, `gnt` = 0, and the next grant goes to requester 0.
